tx_record_store: RTL

Parametrised transaction-record buffer feeding the hashing/signing path. Accepts raw transaction words over a valid/ready handshake, validates them, lane-reverses them into hash order, and stores them in a DEPTH-entry circular queue. It presents the oldest record as a stream, and any queued record through a random-offset peek port. It supersedes the fixed 1K×256 loader with configurable width, depth, overflow mode, flush and statistics.

---
 rtl/tx_record_store.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tx_record_store.sv
// Transaction-record queue: validates incoming words, reverses their 32-bit lanes
// into hash order and buffers them in a circular store with stream and peek reads.
module tx_record_store #(
    parameter int DATA_W    = 256,
    parameter int DEPTH     = 64,
    parameter int RCPT_W    = 160,
    parameter int WRAP_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic [$clog2(DEPTH)-1:0] peek_off,
    input  logic                     peek_req,
    output logic [DATA_W-1:0]        peek_data,
    output logic                     peek_hit,
    output logic                     peek_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_invalid,
    output logic                     err_full,
    output logic [CNT_W-1:0]         accepted_cnt,
    output logic [CNT_W-1:0]         rejected_cnt,
    output logic [CNT_W-1:0]         dropped_cnt
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = DATA_W / 32;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE} state_e;

    function automatic logic [DATA_W-1:0] fmt(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[32*i +: 32] = w[32*(LANES-1-i) +: 32];
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]       count_q, count_d;
    logic              ready_q;
    logic              err_inv_q, err_full_q;
    logic [CNT_W-1:0]  acc_q, acc_d, rej_q, rej_d, drop_q, drop_d;
    logic              peek_ack_q, peek_hit_q, peek_hit_d;
    logic [DATA_W-1:0] peek_data_q, peek_data_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic pop, full, word_bad, set_inv, set_full, wr_en, drop;
    logic [AW-1:0] peek_idx;

    assign in_ready  = ready_q && (state_q == S_IDLE) && !flush;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem[rd_q] : '0;
    assign pop       = out_valid && out_ready && !flush;
    assign full      = (count_q == FULL_CNT);
    assign word_bad  = (word_q == '0) || (word_q[RCPT_W-1:0] == '0);
    assign drop      = wr_en && full && !pop && (WRAP_MODE != 0);
    assign peek_idx  = rd_q + peek_off;

    assign count        = count_q;
    assign err_invalid  = err_inv_q;
    assign err_full     = err_full_q;
    assign accepted_cnt = acc_q;
    assign rejected_cnt = rej_q;
    assign dropped_cnt  = drop_q;
    assign peek_ack     = peek_ack_q;
    assign peek_hit     = peek_hit_q;
    assign peek_data    = peek_data_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d  = state_q;
        word_d   = word_q;
        set_inv  = 1'b0;
        set_full = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            S_IDLE: if (in_valid && in_ready) begin
                word_d  = in_data;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (word_bad) begin
                    set_inv = 1'b1;
                    state_d = S_IDLE;
                end else if (full && (WRAP_MODE == 0) && !pop) begin
                    set_full = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush discards any in-flight word silently.
        if (flush) begin
            state_d  = S_IDLE;
            set_inv  = 1'b0;
            set_full = 1'b0;
            wr_en    = 1'b0;
        end
    end

    always_comb begin
        rd_d    = rd_q + AW'(pop || drop);
        wr_d    = wr_q + AW'(wr_en);
        count_d = count_q;
        if (wr_en && !drop && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !wr_en)          count_d = count_q - (AW+1)'(1);
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end
        acc_d  = wr_en ? sat_inc(acc_q) : acc_q;
        rej_d  = (set_inv || set_full) ? sat_inc(rej_q) : rej_q;
        drop_d = drop ? sat_inc(drop_q) : drop_q;
        // Peek sees pointers and count as they stand before this cycle's pop or write.
        peek_hit_d  = peek_req && !flush && ({1'b0, peek_off} < count_q);
        peek_data_d = peek_hit_d ? mem[peek_idx] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            err_inv_q   <= 1'b0;
            err_full_q  <= 1'b0;
            acc_q       <= '0;
            rej_q       <= '0;
            drop_q      <= '0;
            peek_ack_q  <= 1'b0;
            peek_hit_q  <= 1'b0;
            peek_data_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            ready_q     <= 1'b1;
            err_inv_q   <= set_inv;
            err_full_q  <= set_full;
            acc_q       <= acc_d;
            rej_q       <= rej_d;
            drop_q      <= drop_d;
            peek_ack_q  <= peek_req;
            peek_hit_q  <= peek_hit_d;
            peek_data_q <= peek_data_d;
        end
    end

    // NOTE: the record store has no reset; count gates every read so stale contents never leak.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q] <= fmt(word_q);
    end
endmodule
